// File: rtl/lsu_mem_pkg.sv
// Shared types and decode helpers for the load/store memory master.
package lsu_mem_pkg;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3)
         F3_H, F3_HU: return addr_lo[0];
         F3_W:        return (addr_lo != 2'b00);
         default:     return 1'b0;
      endcase
   endfunction

   // Unsigned widths exist only for loads.
   function automatic logic is_illegal(input logic [2:0] funct3, input logic we);
      case (funct3)
         F3_B, F3_H, F3_W: return 1'b0;
         F3_BU, F3_HU:     return we;
         default:          return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extraction/extension and sub-word store merge.
module lsu_lane_align
   import lsu_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rd_word,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v    = rd_word[{addr_lo, 3'b000} +: 8];
      half_v    = rd_word[{addr_lo[1], 4'b0000} +: 16];
      load_data = '0;
      case (funct3)
         F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
         F3_BU:   load_data = {24'd0, byte_v};
         F3_H:    load_data = {{16{half_v[15]}}, half_v};
         F3_HU:   load_data = {16'd0, half_v};
         F3_W:    load_data = rd_word;
         default: load_data = '0;
      endcase
   end

   always_comb begin
      store_word = old_word;
      case (funct3)
         F3_B:    store_word[{addr_lo, 3'b000} +: 8]    = wdata[7:0];
         F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         F3_W:    store_word = wdata;
         default: store_word = old_word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for word-addressed memory; sub-word stores use read-modify-write.
// Optional statistics counters are built when LSU_MEM_MASTER_STATS_EN is defined.
module lsu_mem_master
   import lsu_mem_pkg::*;
#(
   parameter int C_ADDR_WIDTH = 32,
   parameter int C_DATA_WIDTH = 32,
   parameter int C_STAT_WIDTH = 16
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [2:0]              req_funct3,
   input  logic [C_ADDR_WIDTH-1:0] req_addr,
   input  logic [C_DATA_WIDTH-1:0] req_wdata,
   output logic                    resp_valid,
   output logic [C_DATA_WIDTH-1:0] resp_rdata,
   output logic                    resp_err,
   output logic [C_ADDR_WIDTH-1:0] mem_addr,
   output logic                    mem_write_en,
   output logic [C_DATA_WIDTH-1:0] mem_write_data,
   input  logic [C_DATA_WIDTH-1:0] mem_read_data
`ifdef LSU_MEM_MASTER_STATS_EN
   ,
   output logic [C_STAT_WIDTH-1:0] stat_loads,
   output logic [C_STAT_WIDTH-1:0] stat_stores,
   output logic [C_STAT_WIDTH-1:0] stat_errs
`endif
);

   // Handshake: a request transfers on the rising edge where req_valid && req_ready;
   // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse with no backpressure.
   lsu_state_t state_q, state_d;

   logic                    we_q;
   logic [2:0]              f3_q;
   logic [1:0]              addr_lo_q;
   logic [C_DATA_WIDTH-1:0] wdata_q;
   logic [C_DATA_WIDTH-1:0] old_word_q;
   logic [C_DATA_WIDTH-1:0] rdata_q;
   logic                    err_q;
   logic [C_ADDR_WIDTH-1:0] mem_addr_q;

   logic                    accept;
   logic                    accept_err;
   logic [C_DATA_WIDTH-1:0] load_data;
   logic [C_DATA_WIDTH-1:0] store_word;

   assign accept     = (state_q == IDLE) && req_valid;
   assign accept_err = is_illegal(req_funct3, req_we) || is_misaligned(req_funct3, req_addr[1:0]);

   lsu_lane_align u_align (
      .funct3     (f3_q),
      .addr_lo    (addr_lo_q),
      .rd_word    (mem_read_data),
      .old_word   (old_word_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (accept_err)                          state_d = RESP;
               else if (req_we && (req_funct3 == F3_W)) state_d = WRITE;
               else                                     state_d = READ;
            end
         end
         READ:    state_d = we_q ? WRITE : RESP;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         f3_q       <= '0;
         addr_lo_q  <= '0;
         wdata_q    <= '0;
         old_word_q <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         if (accept) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            err_q     <= accept_err;
            rdata_q   <= '0;
            // Errors never touch memory, so the port address is left alone.
            if (!accept_err) mem_addr_q <= {req_addr[C_ADDR_WIDTH-1:2], 2'b00};
         end
         if (state_q == READ) begin
            old_word_q <= mem_read_data;
            if (!we_q) rdata_q <= load_data;
         end
      end
   end

   always_comb begin
      req_ready      = (state_q == IDLE);
      resp_valid     = (state_q == RESP);
      mem_write_en   = (state_q == WRITE);
      mem_write_data = mem_write_en ? store_word : '0;
      mem_addr       = mem_addr_q;
      resp_rdata     = rdata_q;
      resp_err       = err_q;
   end

`ifdef LSU_MEM_MASTER_STATS_EN
   localparam logic [C_STAT_WIDTH-1:0] STAT_ONE = C_STAT_WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else if (state_q == RESP) begin
         if (err_q) begin
            if (stat_errs != '1) stat_errs <= stat_errs + STAT_ONE;
         end else if (we_q) begin
            if (stat_stores != '1) stat_stores <= stat_stores + STAT_ONE;
         end else begin
            if (stat_loads != '1) stat_loads <= stat_loads + STAT_ONE;
         end
      end
   end
`else
   // Keeps the counter width referenced when the counters are compiled out.
   logic [C_STAT_WIDTH-1:0] stats_unused;
   assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, corner sequences, random vs model.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_write_en;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
`ifdef LSU_MEM_MASTER_STATS_EN
   logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

   lsu_mem_master dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_addr       (mem_addr),
      .mem_write_en   (mem_write_en),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
`ifdef LSU_MEM_MASTER_STATS_EN
      ,
      .stat_loads     (stat_loads),
      .stat_stores    (stat_stores),
      .stat_errs      (stat_errs)
`endif
   );

   always #5 clk = ~clk;

   // System memory seen by the DUT (256 words, byte addresses 0..0x3FF).
   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];
   int          wr_count = 0;
   logic [31:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;

   assign mem_read_data = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[mem_addr[9:2]] = mem_write_data;
         last_wr_addr = mem_addr;
         last_wr_data = mem_write_data;
         wr_count = wr_count + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   int e_loads = 0, e_stores = 0, e_errs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic count_class(input logic err, input logic we);
      if (err)     e_errs++;
      else if (we) e_stores++;
      else         e_loads++;
   endtask

   // Issues one request and waits (bounded) for its response pulse.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int writes);
      int   w0;
      logic busy_ok;
      @(negedge clk);
      chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      w0 = wr_count;
      busy_ok = 1'b1;
      lat = 0; rdata = 'x; err = 1'bx;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (req_ready) busy_ok = 1'b0;
         if (resp_valid) begin
            lat = k; rdata = resp_rdata; err = resp_err;
            break;
         end
      end
      writes = wr_count - w0;
      chk({tag, ".ready_busy"}, 32'(busy_ok), 32'd1);
   endtask

   // Reference behaviour computed directly from the access rules.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic err, output int lat, output int nwr);
      int unsigned size, sh, idx;
      logic [31:0] w, v, mask;
      logic legal;
      legal = (f3 == 0 || f3 == 1 || f3 == 2 || (!we && (f3 == 4 || f3 == 5)));
      size  = 1 << (f3 % 4);
      idx   = (addr % 1024) / 4;
      sh    = 8 * (addr % 4);
      err   = !legal || ((addr % size) != 0);
      rd = 0; nwr = 0;
      if (err) begin
         lat = 1;
      end else if (!we) begin
         lat = 2;
         w = ref_mem[idx];
         v = w >> sh;
         if (size == 1) begin
            v = v & 32'hFF;
            if (f3 < 4 && v >= 32'h80) v = v | 32'hFFFFFF00;
         end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (f3 < 4 && v >= 32'h8000) v = v | 32'hFFFF0000;
         end
         rd = v;
      end else begin
         lat  = (size == 4) ? 2 : 3;
         nwr  = 1;
         mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 1);
         ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
      end
   endfunction

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [16];

   initial begin
      logic [31:0] rd, erd, wd, addr, val;
      logic        er, eer, we;
      logic [2:0]  f3;
      int          lat, elat, nw, enw, w0;
      string       tag;

      vecs[0]  = '{1'b0, 3'd0, 32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0, 32'h8899AABB};
      vecs[1]  = '{1'b0, 3'd4, 32'h101, 32'h0,        32'h000000AA, 1'b0, 2, 0, 32'h8899AABB};
      vecs[2]  = '{1'b0, 3'd5, 32'h102, 32'h0,        32'h00008899, 1'b0, 2, 0, 32'h8899AABB};
      vecs[3]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'hFFFF8899, 1'b0, 2, 0, 32'h8899AABB};
      vecs[4]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 2, 0, 32'h8899AABB};
      vecs[5]  = '{1'b1, 3'd0, 32'h103, 32'h12,       32'h0,        1'b0, 3, 1, 32'h1299AABB};
      vecs[6]  = '{1'b1, 3'd1, 32'h100, 32'hCAFE,     32'h0,        1'b0, 3, 1, 32'h8899CAFE};
      vecs[7]  = '{1'b1, 3'd2, 32'h102, 32'h5555,     32'h0,        1'b1, 1, 0, 32'h8899AABB};
      vecs[8]  = '{1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 32'h8899AABB};
      vecs[9]  = '{1'b1, 3'd4, 32'h100, 32'h12,       32'h0,        1'b1, 1, 0, 32'h8899AABB};
      vecs[10] = '{1'b0, 3'd1, 32'h101, 32'h0,        32'h0,        1'b1, 1, 0, 32'h8899AABB};
      vecs[11] = '{1'b1, 3'd2, 32'h100, 32'h01020304, 32'h0,        1'b0, 2, 1, 32'h01020304};
      vecs[12] = '{1'b0, 3'd0, 32'h100, 32'h0,        32'hFFFFFFBB, 1'b0, 2, 0, 32'h8899AABB};
      vecs[13] = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h00000088, 1'b0, 2, 0, 32'h8899AABB};
      vecs[14] = '{1'b0, 3'd7, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 32'h8899AABB};
      vecs[15] = '{1'b1, 3'd0, 32'h100, 32'hFFFFFF7F, 32'h0,        1'b0, 3, 1, 32'h8899AA7F};

      for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.req_ready", 32'(req_ready), 32'd1);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.resp_rdata", resp_rdata, 32'd0);
      chk("rst.resp_err", 32'(resp_err), 32'd0);
      chk("rst.mem_write_en", 32'(mem_write_en), 32'd0);
      chk("rst.mem_addr", mem_addr, 32'd0);
      chk("rst.mem_write_data", mem_write_data, 32'd0);
`ifdef LSU_MEM_MASTER_STATS_EN
      chk("rst.stat_loads", 32'(stat_loads), 32'd0);
      chk("rst.stat_stores", 32'(stat_stores), 32'd0);
      chk("rst.stat_errs", 32'(stat_errs), 32'd0);
`endif
      rst_n = 1'b1;

      // Reset during the READ of a sub-word store
      mem[8'h41] = 32'h11223344;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h104; req_wdata = 32'h55;
      w0 = wr_count;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst.mem_write_en", 32'(mem_write_en), 32'd0);
      chk("midrst.req_ready", 32'(req_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst.writes", 32'(wr_count - w0), 32'd0);
      chk("midrst.mem_word", mem[8'h41], 32'h11223344);
      chk("midrst.ready_after", 32'(req_ready), 32'd1);

      // Directed vector table
      foreach (vecs[i]) begin
         mem[8'h40] = 32'h8899AABB;
         tag = $sformatf("vec%0d", i);
         run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, tag, rd, er, lat, nw);
         count_class(vecs[i].exp_err, vecs[i].we);
         chk({tag, ".rdata"}, rd, vecs[i].exp_rdata);
         chk({tag, ".err"}, 32'(er), 32'(vecs[i].exp_err));
         chk({tag, ".latency"}, 32'(lat), 32'(vecs[i].exp_lat));
         chk({tag, ".writes"}, 32'(nw), 32'(vecs[i].exp_wr));
         chk({tag, ".word"}, mem[8'h40], vecs[i].exp_word);
         if (vecs[i].exp_wr == 1) begin
            chk({tag, ".wr_addr"}, last_wr_addr, vecs[i].addr & 32'hFFFFFFFC);
            chk({tag, ".wr_data"}, last_wr_data, vecs[i].exp_word);
         end
      end

      // Back-to-back with req_valid held: SW@0x200 then LW@0x200
      wd = $urandom;
      mem[8'h80] = '0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h200; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      chk("b2b.ready_k1", 32'(req_ready), 32'd0);
      req_we = 1'b0; req_wdata = '0;
      @(negedge clk);
      chk("b2b.ready_k2", 32'(req_ready), 32'd0);
      chk("b2b.sw_resp", 32'(resp_valid), 32'd1);
      chk("b2b.sw_err", 32'(resp_err), 32'd0);
      @(negedge clk);
      chk("b2b.ready_k3", 32'(req_ready), 32'd1);
      chk("b2b.resp_k3", 32'(resp_valid), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b.ready_k4", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("b2b.lw_resp", 32'(resp_valid), 32'd1);
      chk("b2b.lw_rdata", resp_rdata, wd);
      count_class(1'b0, 1'b1);
      count_class(1'b0, 1'b0);

      // Random traffic against the reference model
      for (int i = 0; i < 256; i++) begin
         val = $urandom;
         mem[i] = val;
         ref_mem[i] = val;
      end
      for (int n = 0; n < 300; n++) begin
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         addr = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         wd   = $urandom;
         tag  = $sformatf("rnd%0d", n);
         model(we, f3, addr, wd, erd, eer, elat, enw);
         count_class(eer, we);
         run_req(we, f3, addr, wd, tag, rd, er, lat, nw);
         chk({tag, ".rdata"}, rd, erd);
         chk({tag, ".err"}, 32'(er), 32'(eer));
         chk({tag, ".latency"}, 32'(lat), 32'(elat));
         chk({tag, ".writes"}, 32'(nw), 32'(enw));
         if (we) chk({tag, ".word"}, mem[addr[9:2]], ref_mem[addr[9:2]]);
      end

`ifdef LSU_MEM_MASTER_STATS_EN
      @(negedge clk);
      chk("stat_loads", 32'(stat_loads), 32'(e_loads));
      chk("stat_stores", 32'(stat_stores), 32'(e_stores));
      chk("stat_errs", 32'(stat_errs), 32'(e_errs));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
